// File: rtl/mips32_mem_pkg.sv
// Shared definitions for the MIPS32 memory responder slice.
// Holds the FSM state encoding, the default storage depth and the
// width of the word index used to address the storage array.
package mips32_mem_pkg;

   localparam int MEM_DEPTH_DEFAULT = 512;
   localparam int MEM_ADDR_W        = 9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mips32_mem_responder_if.sv
// Request/response bus between an initiator (master) and the memory
// responder (slave). Optional macro MIPS32_MEM_BYTE_WR_EN adds the
// req_be byte-enable lane.
interface mips32_mem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

`ifdef MIPS32_MEM_BYTE_WR_EN
   logic [3:0]  req_be;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
`else
   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
`endif

endinterface

// File: rtl/mips32_mem_array.sv
// Synchronous single-port word storage with a per-byte write mask.
// A write updates only the enabled byte lanes; a read registers the
// addressed word on the same edge. Contents are never reset.
module mips32_mem_array
   import mips32_mem_pkg::*;
#(
   parameter int DEPTH = MEM_DEPTH_DEFAULT
)
(
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [3:0]            be,
   input  logic [MEM_ADDR_W-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [DEPTH];

   // Single access port: masked byte write, or registered word read
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) begin
                  mem[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/mips32_mem_responder.sv
// MIPS32 memory responder: accepts one load/store at a time, inserts
// WAIT_CYCLES wait states, then presents a response until taken.
// The array access happens on the edge that enters RESP, so the WAIT
// state always spans WAIT_CYCLES+1 cycles; with WAIT_CYCLES = 0 it
// collapses to the single array access cycle and no wait states.
// Optional macro MIPS32_MEM_BYTE_WR_EN enables byte-masked stores.
module mips32_mem_responder
   import mips32_mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH       = MEM_DEPTH_DEFAULT
)
(
   input  logic                     clk,
   input  logic                     rst,
   mips32_mem_responder_if.slave    bus
);

   mem_state_e            state;
   logic [3:0]            wait_cnt;
   logic                  cap_we;
   logic                  cap_err;
   logic [MEM_ADDR_W-1:0] cap_idx;
   logic [31:0]           cap_wdata;
   logic                  req_ready_q;
   logic                  rsp_valid_q;
   logic                  rsp_err_q;
   logic                  rsp_load_q;

   logic                  mem_en;
   logic [3:0]            mem_be;
   logic [31:0]           mem_rdata;

`ifdef MIPS32_MEM_BYTE_WR_EN
   logic [3:0]            cap_be;
   assign mem_be = cap_be;
`else
   assign mem_be = 4'hF;
`endif

   assign mem_en = (state == ST_WAIT) && (wait_cnt == 4'd0) && !cap_err;

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_load_q ? mem_rdata : 32'd0;

   mips32_mem_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk   (clk),
      .en    (mem_en),
      .we    (cap_we),
      .be    (mem_be),
      .addr  (cap_idx),
      .wdata (cap_wdata),
      .rdata (mem_rdata)
   );

   // Request/response sequencing with registered handshake outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         wait_cnt    <= 4'd0;
         cap_we      <= 1'b0;
         cap_err     <= 1'b0;
         cap_idx     <= '0;
         cap_wdata   <= 32'd0;
`ifdef MIPS32_MEM_BYTE_WR_EN
         cap_be      <= 4'd0;
`endif
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_load_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  cap_we      <= bus.req_we;
                  cap_err     <= (bus.req_addr >= 32'(DEPTH));
                  cap_idx     <= bus.req_addr[MEM_ADDR_W-1:0];
                  cap_wdata   <= bus.req_wdata;
`ifdef MIPS32_MEM_BYTE_WR_EN
                  cap_be      <= bus.req_be;
`endif
                  wait_cnt    <= 4'(WAIT_CYCLES);
                  req_ready_q <= 1'b0;
                  state       <= ST_WAIT;
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= cap_err;
                  rsp_load_q  <= !cap_we && !cap_err;
                  state       <= ST_RESP;
               end else begin
                  wait_cnt    <= wait_cnt - 4'd1;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  rsp_load_q  <= 1'b0;
                  req_ready_q <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Scoreboard bench for mips32_mem_responder. Two instances are used:
// dut 0 with WAIT_CYCLES = 2 and dut 1 with WAIT_CYCLES = 0. Stimulus
// pushes expected responses into a queue; a monitor pops and compares
// them (data, error flag, latency) whenever a response is taken.
`timescale 1ns/1ps
module tb_mips32_mem_responder;
   import mips32_mem_pkg::*;

   localparam int WC0 = 2;
   localparam int WC1 = 0;

   typedef struct {
      int          dut;
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   exp_t sb_q[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic        clk   = 1'b0;
   logic [1:0]  rst_n = 2'b00;

   logic [1:0]  drv_valid     = 2'b00;
   logic [1:0]  drv_we        = 2'b00;
   logic [1:0]  drv_rsp_ready = 2'b11;
   logic [31:0] drv_addr  [2];
   logic [31:0] drv_wdata [2];
`ifdef MIPS32_MEM_BYTE_WR_EN
   logic [3:0]  drv_be    [2];
`endif

   logic [1:0]  mon_req_ready;
   logic [1:0]  mon_rsp_valid;
   logic [1:0]  mon_rsp_err;
   logic [31:0] mon_rsp_rdata [2];

   mips32_mem_responder_if bus_a ();
   mips32_mem_responder_if bus_b ();

   assign bus_a.req_valid = drv_valid[0];
   assign bus_a.req_we    = drv_we[0];
   assign bus_a.req_addr  = drv_addr[0];
   assign bus_a.req_wdata = drv_wdata[0];
   assign bus_a.rsp_ready = drv_rsp_ready[0];
   assign bus_b.req_valid = drv_valid[1];
   assign bus_b.req_we    = drv_we[1];
   assign bus_b.req_addr  = drv_addr[1];
   assign bus_b.req_wdata = drv_wdata[1];
   assign bus_b.rsp_ready = drv_rsp_ready[1];
`ifdef MIPS32_MEM_BYTE_WR_EN
   assign bus_a.req_be    = drv_be[0];
   assign bus_b.req_be    = drv_be[1];
`endif

   assign mon_req_ready[0] = bus_a.req_ready;
   assign mon_rsp_valid[0] = bus_a.rsp_valid;
   assign mon_rsp_err[0]   = bus_a.rsp_err;
   assign mon_rsp_rdata[0] = bus_a.rsp_rdata;
   assign mon_req_ready[1] = bus_b.req_ready;
   assign mon_rsp_valid[1] = bus_b.rsp_valid;
   assign mon_rsp_err[1]   = bus_b.rsp_err;
   assign mon_rsp_rdata[1] = bus_b.rsp_rdata;

   mips32_mem_responder #(.WAIT_CYCLES(WC0), .DEPTH(512)) dut_a (
      .clk (clk),
      .rst (rst_n[0]),
      .bus (bus_a.slave)
   );

   mips32_mem_responder #(.WAIT_CYCLES(WC1), .DEPTH(512)) dut_b (
      .clk (clk),
      .rst (rst_n[1]),
      .bus (bus_b.slave)
   );

   // Free-running clock and posedge cycle counter
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop if the run never reaches its summary
   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int wc_of(input int d);
      return (d == 0) ? WC0 : WC1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s actual=timeout required=event", name);
   endtask

   // Monitor: idle outputs must be zero; each taken response is scored
   int   rise_cyc [2];
   logic [1:0] prev_valid = 2'b00;
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (mon_rsp_valid[d] && !prev_valid[d]) rise_cyc[d] = cyc;
         if (!mon_rsp_valid[d]) begin
            checkOutput("idle_rdata", mon_rsp_rdata[d], 32'd0);
            checkOutput("idle_err", 32'(mon_rsp_err[d]), 32'd0);
         end else if (drv_rsp_ready[d]) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_rsp actual=dut%0d_response required=none", d);
            end else begin
               e = sb_q.pop_front();
               checkOutput("rsp_dut", 32'(d), 32'(e.dut));
               checkOutput("rsp_rdata", mon_rsp_rdata[d], e.rdata);
               checkOutput("rsp_err", 32'(mon_rsp_err[d]), 32'(e.err));
               checkOutput("rsp_latency", 32'(rise_cyc[d]), 32'(e.due));
            end
         end
      end
      prev_valid = mon_rsp_valid;
   end

   // Present one request, wait for acceptance, then scramble the inputs
   task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input bit push, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      drv_valid[d] = 1'b1;
      drv_we[d]    = we;
      drv_addr[d]  = addr;
      drv_wdata[d] = wdata;
`ifdef MIPS32_MEM_BYTE_WR_EN
      drv_be[d]    = be;
`else
      if (be != 4'hF) $display("[TB] note: byte enables ignored in this build");
`endif
      while (!mon_req_ready[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!mon_req_ready[d]) begin
         failNow("accept_timeout");
         drv_valid[d] = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc + 1;
      if (push) sb_q.push_back('{d, exp_rdata, exp_err, acc + wc_of(d) + 1});
      @(posedge clk);
      #1;
      drv_valid[d] = 1'b0;
      drv_we[d]    = ~we;
      drv_addr[d]  = ~addr;
      drv_wdata[d] = ~wdata;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         failNow("drain_timeout");
         sb_q.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int acc;
      int acc_prev;
      int n;
      drv_addr[0] = 32'd0;  drv_addr[1] = 32'd0;
      drv_wdata[0] = 32'd0; drv_wdata[1] = 32'd0;
`ifdef MIPS32_MEM_BYTE_WR_EN
      drv_be[0] = 4'hF;     drv_be[1] = 4'hF;
`endif
      $display("[TB] start");

      // Reset state
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checkOutput("reset_req_ready", 32'(mon_req_ready[d]), 32'd0);
         checkOutput("reset_rsp_valid", 32'(mon_rsp_valid[d]), 32'd0);
      end
      rst_n = 2'b11;
      @(negedge clk);
      checkOutput("post_reset_req_ready", 32'(mon_req_ready[0]), 32'd1);

      // Store then load, latency WAIT_CYCLES+1
      applyStimulus(0, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, 1'b1, acc);
      applyStimulus(0, 1'b0, 32'd5, 32'd0,        4'hF, 32'hDEADBEEF, 1'b0, 1'b1, acc);
      drain();

      // Out-of-range accesses: error, no write, no aliasing onto 88
      applyStimulus(0, 1'b1, 32'd88,  32'hCAFE0088, 4'hF, 32'd0, 1'b0, 1'b1, acc);
      applyStimulus(0, 1'b1, 32'd600, 32'h12345678, 4'hF, 32'd0, 1'b1, 1'b1, acc);
      applyStimulus(0, 1'b0, 32'd600, 32'd0,        4'hF, 32'd0, 1'b1, 1'b1, acc);
      applyStimulus(0, 1'b0, 32'd88,  32'd0,        4'hF, 32'hCAFE0088, 1'b0, 1'b1, acc);
      drain();

      // Response held under back-pressure while req_valid toggles
      drv_rsp_ready[0] = 1'b0;
      applyStimulus(0, 1'b0, 32'd5, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1, acc);
      n = 0;
      while (!mon_rsp_valid[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!mon_rsp_valid[0]) failNow("hold_rsp_timeout");
      drv_addr[0] = 32'd7;
      drv_we[0]   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drv_valid[0] = ~drv_valid[0];
         checkOutput("hold_rsp_valid", 32'(mon_rsp_valid[0]), 32'd1);
         checkOutput("hold_rsp_rdata", mon_rsp_rdata[0], 32'hDEADBEEF);
         checkOutput("hold_rsp_err", 32'(mon_rsp_err[0]), 32'd0);
         checkOutput("hold_req_ready", 32'(mon_req_ready[0]), 32'd0);
      end
      @(negedge clk);
      drv_valid[0]     = 1'b0;
      drv_rsp_ready[0] = 1'b1;
      drain();
      repeat (6) @(negedge clk);
      checkOutput("hold_back_to_idle", 32'(mon_req_ready[0]), 32'd1);

      // Reset during WAIT abandons the uncommitted store
      applyStimulus(0, 1'b1, 32'd7, 32'h11111111, 4'hF, 32'd0, 1'b0, 1'b1, acc);
      drain();
      applyStimulus(0, 1'b1, 32'd7, 32'h22222222, 4'hF, 32'd0, 1'b0, 1'b0, acc);
      @(posedge clk);
      #2;
      rst_n[0] = 1'b0;
      @(negedge clk);
      checkOutput("midreset_req_ready", 32'(mon_req_ready[0]), 32'd0);
      checkOutput("midreset_rsp_valid", 32'(mon_rsp_valid[0]), 32'd0);
      @(negedge clk);
      rst_n[0] = 1'b1;
      applyStimulus(0, 1'b0, 32'd7, 32'd0, 4'hF, 32'h11111111, 1'b0, 1'b1, acc);
      drain();

      // Zero wait states: back-to-back loads every 3 cycles
      applyStimulus(1, 1'b1, 32'd40, 32'hA5A50040, 4'hF, 32'd0, 1'b0, 1'b1, acc);
      applyStimulus(1, 1'b1, 32'd41, 32'h5A5A0041, 4'hF, 32'd0, 1'b0, 1'b1, acc);
      drain();
      applyStimulus(1, 1'b0, 32'd40, 32'd0, 4'hF, 32'hA5A50040, 1'b0, 1'b1, acc_prev);
      applyStimulus(1, 1'b0, 32'd41, 32'd0, 4'hF, 32'h5A5A0041, 1'b0, 1'b1, acc);
      checkOutput("b2b_spacing_1", 32'(acc - acc_prev), 32'd3);
      acc_prev = acc;
      applyStimulus(1, 1'b0, 32'd40, 32'd0, 4'hF, 32'hA5A50040, 1'b0, 1'b1, acc);
      checkOutput("b2b_spacing_2", 32'(acc - acc_prev), 32'd3);
      drain();

`ifdef MIPS32_MEM_BYTE_WR_EN
      // Byte-masked store over a zeroed word
      applyStimulus(0, 1'b1, 32'd20, 32'h00000000, 4'hF,    32'd0, 1'b0, 1'b1, acc);
      applyStimulus(0, 1'b1, 32'd20, 32'hAABBCCDD, 4'b0101, 32'd0, 1'b0, 1'b1, acc);
      applyStimulus(0, 1'b0, 32'd20, 32'd0,        4'hF,    32'h00BB00DD, 1'b0, 1'b1, acc);
      drain();
`endif

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips32_mem_responder.md
MIPS32_MEM_RESPONDER -- requirements
Module: mips32_mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states between request acceptance and response (0..15).
REQ-002 SHALL have parameter DEPTH, default 512, meaning number of 32-bit words stored.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  word address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  initiator takes response.
REQ-012 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  address >= DEPTH.

Function
REQ-014 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT skipped when WAIT_CYCLES = 0.
REQ-015 SHALL drive req_ready = 1 only in IDLE; request accepted on an edge with req_valid & req_ready.
REQ-016 SHALL register req_we, req_addr, req_wdata at acceptance; later input changes are ignored.
REQ-017 SHALL assert rsp_valid exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-018 SHALL commit a store to the array on the edge entering RESP; a load samples the array on that same edge.
REQ-019 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until an edge with rsp_ready = 1, then return to IDLE.
REQ-020 SHALL NOT accept a new request in the same cycle a response completes; next acceptance is earliest one cycle later.
REQ-021 SHALL, for req_addr >= DEPTH: perform no write, return rsp_rdata = 0, rsp_err = 1, with normal latency.
REQ-022 SHALL use only req_addr bits [8:0] for indexing when in range.
REQ-023 SHALL ignore req_valid outside IDLE; rsp_ready outside RESP has no effect.
REQ-024 SHALL drive rsp_rdata = 0 and rsp_err = 0 whenever rsp_valid = 0.

Reset
REQ-025 SHALL on rst low force IDLE, req_ready = 0 while asserted, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
REQ-026 SHALL NOT reset array contents.
REQ-027 SHALL abandon an uncommitted store if reset arrives in WAIT; a store committed before reset persists.

Configuration
REQ-028 SHALL, with MIPS32_MEM_BYTE_WR_EN defined, add port req_be input 4 byte enables captured at acceptance; a store writes only enabled bytes (bit i = bits [8i+7:8i]).
REQ-029 SHALL, without MIPS32_MEM_BYTE_WR_EN, have no req_be port and stores write all 32 bits.

Structure
REQ-030 SHALL place the FSM state enum, DEPTH default, and address width constant (9) in package mips32_mem_pkg.
REQ-031 SHALL instantiate one sub-module mips32_mem_array (synchronous single-port storage, write-with-byte-mask).

Verification
REQ-032 Reset then store addr 5 data 0xDEADBEEF, load addr 5, WAIT_CYCLES = 2 -> rsp_valid 3 cycles after each acceptance; load returns 0xDEADBEEF, rsp_err = 0.
REQ-033 Load addr 600 -> rsp_err = 1, rsp_rdata = 0; then load addr 88 (600 mod 512) -> unchanged prior contents.
REQ-034 Hold rsp_ready = 0 for 5 cycles in RESP while toggling req_valid -> response stable, req_ready = 0, no second acceptance.
REQ-035 Store addr 7 0x11111111, assert rst during WAIT of store addr 7 0x22222222, load addr 7 -> 0x11111111.
REQ-036 WAIT_CYCLES = 0, back-to-back loads with rsp_ready = 1 -> one acceptance every 3 cycles, rsp_valid 1 cycle after acceptance.
REQ-037 With MIPS32_MEM_BYTE_WR_EN: store 0xAABBCCDD be = 4'b0101 over 0x00000000, load -> 0x00BB00DD.
